// File: rtl/ir_uart_frame_tx.sv
// Serialises one captured IR frame into a UART byte message. The payload is binary or ASCII-hex
// data, or a fixed "fail" message, with an optional CR/LF tail. Frames offered while busy are counted.
module ir_uart_frame_tx #(
   parameter int DATA_W     = 11,
   parameter int GAP_CYCLES = 600,
   parameter bit HEX_MODE   = 1'b0,
   parameter bit TERM_EN    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_valid,
   input  logic              frame_ok,
   input  logic [DATA_W-1:0] frame_data,
   output logic              frame_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   input  logic              tx_done,
   output logic              msg_done,
   output logic [7:0]        drop_cnt
);
   localparam int NB = (DATA_W + 7) / 8;
   localparam int NH = (DATA_W + 3) / 4;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [3:0] LAST_OK  = 4'(HEX_MODE ? NH - 1 : NB - 1);
   localparam logic [3:0] TERM_ADD = TERM_EN ? 4'd2 : 4'd0;
   localparam logic [2:0] NH_M1    = 3'(NH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ok_q, ok_d;
   logic [3:0]        idx_q, idx_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [7:0]        drop_q, drop_d;

   logic [3:0][7:0] data_bytes;
   logic [7:0][3:0] data_nibs;
   logic [3:0]      payload_last, last_idx, nib;
   logic [2:0]      nib_sel;
   logic [7:0]      hex_char, cur_byte;

   assign data_bytes = 32'(data_q);
   assign data_nibs  = 32'(data_q);

   // Byte at the current index: payload first (hex digits MSB first), then the CR/LF tail.
   always_comb begin
      payload_last = ok_q ? LAST_OK : 4'd3;
      last_idx     = payload_last + TERM_ADD;
      nib_sel      = NH_M1 - idx_q[2:0];
      nib          = data_nibs[nib_sel];
      hex_char     = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      cur_byte     = 8'h00;
      if (idx_q > payload_last) begin
         cur_byte = (idx_q == payload_last + 4'd1) ? 8'h0D : 8'h0A;
      end else if (!ok_q) begin
         case (idx_q[1:0])
            2'd0:    cur_byte = 8'h66;
            2'd1:    cur_byte = 8'h61;
            2'd2:    cur_byte = 8'h69;
            default: cur_byte = 8'h6C;
         endcase
      end else if (HEX_MODE) begin
         cur_byte = hex_char;
      end else begin
         cur_byte = data_bytes[idx_q[1:0]];
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      ok_d        = ok_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      tx_data_d   = tx_data_q;
      drop_d      = drop_q;
      frame_ready = (state_q == S_IDLE);
      tx_start    = 1'b0;
      tx_data     = tx_data_q;
      msg_done    = 1'b0;

      if (frame_valid && state_q != S_IDLE && drop_q != 8'hFF) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (frame_valid) begin
               data_d  = frame_data;
               ok_d    = frame_ok;
               idx_d   = 4'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tx_data = cur_byte;
            if (!tx_busy) begin
               tx_start  = 1'b1;
               tx_data_d = cur_byte;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               if (idx_q == last_idx) begin
                  msg_done = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_ISSUE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         ok_q      <= 1'b0;
         idx_q     <= 4'd0;
         gap_q     <= '0;
         tx_data_q <= 8'h00;
         drop_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         ok_q      <= ok_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         tx_data_q <= tx_data_d;
         drop_q    <= drop_d;
      end
   end

   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ir_uart_frame_tx.sv
// Directed and randomized bench for ir_uart_frame_tx: a binary instance (long gap) and an
// ASCII-hex instance with CR/LF (short gap), both checked against a byte-list reference model.
module tb_ir_uart_frame_tx;
   localparam int W    = 11;
   localparam int GAP0 = 600;
   localparam int GAP1 = 3;
   localparam int NB   = (W + 7) / 8;
   localparam int NH   = (W + 3) / 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic         fv[2], fok[2], busy_w[2], done_w[2];
   logic [W-1:0] fdat[2];
   logic         ready_w[2], start_w[2], mdone_w[2];
   logic [7:0]   txd_w[2], drop_w[2];

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   ir_uart_frame_tx #(.DATA_W(W), .GAP_CYCLES(GAP0), .HEX_MODE(1'b0), .TERM_EN(1'b0)) dut_bin (
      .clk(clk), .rst(rst), .frame_valid(fv[0]), .frame_ok(fok[0]), .frame_data(fdat[0]),
      .frame_ready(ready_w[0]), .tx_start(start_w[0]), .tx_data(txd_w[0]), .tx_busy(busy_w[0]),
      .tx_done(done_w[0]), .msg_done(mdone_w[0]), .drop_cnt(drop_w[0]));

   ir_uart_frame_tx #(.DATA_W(W), .GAP_CYCLES(GAP1), .HEX_MODE(1'b1), .TERM_EN(1'b1)) dut_hex (
      .clk(clk), .rst(rst), .frame_valid(fv[1]), .frame_ok(fok[1]), .frame_data(fdat[1]),
      .frame_ready(ready_w[1]), .tx_start(start_w[1]), .tx_data(txd_w[1]), .tx_busy(busy_w[1]),
      .tx_done(done_w[1]), .msg_done(mdone_w[1]), .drop_cnt(drop_w[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected message: instance 0 is binary LSB byte first, instance 1 is hex digits plus CR/LF.
   task automatic build_exp(input int k, input logic ok, input logic [W-1:0] d);
      string hexd = "0123456789ABCDEF";
      string fail_s = "fail";
      int v = int'(d);
      exp_q.delete();
      if (!ok) begin
         for (int i = 0; i < 4; i++) exp_q.push_back(fail_s[i]);
      end else if (k == 1) begin
         for (int i = NH - 1; i >= 0; i--) exp_q.push_back(hexd[(v / (16 ** i)) % 16]);
      end else begin
         for (int i = 0; i < NB; i++) exp_q.push_back(8'((v / (256 ** i)) % 256));
      end
      if (k == 1) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic offer(input int k, input logic ok, input logic [W-1:0] d);
      tick();
      fv[k] = 1'b1; fok[k] = ok; fdat[k] = d;
      @(negedge clk);
      check($sformatf("ready_at_offer%0d", k), 32'(ready_w[k]), 32'd1);
      tick();
      fv[k] = 1'b0; fok[k] = 1'($urandom); fdat[k] = W'($urandom);
   endtask

   // UART responder: busy for busy_len cycles after each tx_start, then a one-cycle tx_done.
   task automatic serve(input int k, input int busy_len, input int n_drop, input bit end_offer);
      int cnt = 0;
      bit fin = 1'b0;
      bit st;
      logic [7:0] cur = got_q.size() > 0 ? got_q[got_q.size() - 1] : 8'h00;
      for (int c = 0; c < 5000 && !fin; c++) begin
         @(negedge clk);
         st = start_w[k];
         if (st) begin
            check($sformatf("no_start_while_busy%0d", k), 32'(busy_w[k]), 32'd0);
            got_q.push_back(txd_w[k]);
            cur = txd_w[k];
         end
         if (done_w[k]) check($sformatf("tx_data_held%0d", k), 32'(txd_w[k]), 32'(cur));
         if (mdone_w[k]) fin = 1'b1;
         tick();
         done_w[k] = 1'b0;
         fv[k] = (c < n_drop);
         if (fv[k]) begin
            fok[k] = 1'($urandom); fdat[k] = W'($urandom);
         end
         if (st) begin
            busy_w[k] = 1'b1;
            cnt = busy_len;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               busy_w[k] = 1'b0;
               done_w[k] = 1'b1;
               if (end_offer && got_q.size() == exp_q.size()) fv[k] = 1'b1;
            end
         end
      end
      fv[k] = 1'b0;
      check($sformatf("msg_done_seen%0d", k), 32'(fin), 32'd1);
      check($sformatf("msg_len%0d", k), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("byte%0d_inst%0d", i, k), 32'(got_q[i]), 32'(exp_q[i]));
      @(negedge clk);
      check($sformatf("ready_after_msg%0d", k), 32'(ready_w[k]), 32'd1);
   endtask

   task automatic run_msg(input int k, input logic ok, input logic [W-1:0] d, input int busy_len,
                          input int n_drop, input bit end_offer);
      build_exp(k, ok, d);
      got_q.delete();
      offer(k, ok, d);
      serve(k, busy_len, n_drop, end_offer);
   endtask

   // Edge at which the next tx_start is taken (-1 if none within limit); busy released at edge rel+1.
   task automatic wait_start(input int k, input int limit, input int rel, output int e);
      e = -1;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (start_w[k]) begin
            e = cyc + 1;
            got_q.push_back(txd_w[k]);
            break;
         end
         tick();
         if (rel > 0 && cyc >= rel) busy_w[k] = 1'b0;
      end
      tick();
   endtask

   initial begin
      int e, t_acc, n1, n2, bad;
      logic [W-1:0] d;
      for (int k = 0; k < 2; k++) begin
         fv[k] = 1'b0; fok[k] = 1'b0; fdat[k] = '0; busy_w[k] = 1'b0; done_w[k] = 1'b0;
      end

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_ready%0d", k), 32'(ready_w[k]), 32'd1);
         check($sformatf("rst_start%0d", k), 32'(start_w[k]), 32'd0);
         check($sformatf("rst_txdata%0d", k), 32'(txd_w[k]), 32'd0);
         check($sformatf("rst_msgdone%0d", k), 32'(mdone_w[k]), 32'd0);
         check($sformatf("rst_drop%0d", k), 32'(drop_w[k]), 32'd0);
      end

      // Known frames: binary, hex + CR/LF, and the fail message on both instances
      run_msg(0, 1'b1, 11'h5A3, 4, 0, 1'b0);
      run_msg(1, 1'b1, 11'h5A3, 2, 0, 1'b0);
      run_msg(0, 1'b0, W'($urandom), 3, 0, 1'b0);
      run_msg(1, 1'b0, W'($urandom), 1, 0, 1'b0);

      // A frame offered in the msg_done cycle is dropped, not accepted
      run_msg(1, 1'b1, W'($urandom), 2, 0, 1'b1);
      check("end_offer_dropped", 32'(drop_w[1]), 32'd1);
      wait_start(1, 12, 0, e);
      check("end_offer_not_started", 32'(e), 32'hFFFF_FFFF);

      // Gap timing on the binary instance with a fail message
      build_exp(0, 1'b0, 11'h000);
      got_q.delete();
      tick();
      fv[0] = 1'b1; fok[0] = 1'b0; fdat[0] = W'($urandom);
      t_acc = cyc + 1;
      tick();
      fv[0] = 1'b0;
      wait_start(0, 10, 0, e);
      check("first_start_T+1", 32'(e), 32'(t_acc + 1));
      busy_w[0] = 1'b1;
      repeat (3) tick();
      busy_w[0] = 1'b0; done_w[0] = 1'b1;
      n1 = cyc + 1;
      tick();
      done_w[0] = 1'b0;
      wait_start(0, 1000, 0, e);
      check("gap_start_N+601", 32'(e), 32'(n1 + GAP0 + 1));
      busy_w[0] = 1'b1;
      repeat (2) tick();
      done_w[0] = 1'b1;
      n2 = cyc + 1;
      tick();
      done_w[0] = 1'b0;
      wait_start(0, 1000, n2 + 700, e);
      check("busy_hold_start_N+701", 32'(e), 32'(n2 + 701));
      busy_w[0] = 1'b1;
      repeat (2) tick();
      busy_w[0] = 1'b0; done_w[0] = 1'b1;
      tick();
      done_w[0] = 1'b0;
      serve(0, 4, 0, 1'b0);

      // Drop counting and saturation; the message in flight is unaffected
      run_msg(0, 1'b1, W'($urandom), 5, 3, 1'b0);
      check("drop_cnt_3", 32'(drop_w[0]), 32'd3);
      run_msg(0, 1'b1, W'($urandom), 5, 300, 1'b0);
      check("drop_cnt_sat", 32'(drop_w[0]), 32'd255);

      // Randomized frames
      for (int i = 0; i < 12; i++)
         run_msg(1, ($urandom_range(0, 3) != 0), W'($urandom), $urandom_range(1, 6), 0, 1'b0);
      for (int i = 0; i < 3; i++)
         run_msg(0, ($urandom_range(0, 3) != 0), W'($urandom), $urandom_range(1, 8), 0, 1'b0);

      // Reset while waiting on byte 1; a later tx_done must be ignored
      d = W'($urandom);
      build_exp(0, 1'b1, d);
      got_q.delete();
      offer(0, 1'b1, d);
      wait_start(0, 10, 0, e);
      busy_w[0] = 1'b1;
      tick();
      busy_w[0] = 1'b0; done_w[0] = 1'b1;
      tick();
      done_w[0] = 1'b0;
      wait_start(0, 1000, 0, e);
      busy_w[0] = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; busy_w[0] = 1'b0;
      @(negedge clk);
      check("rst_mid_start", 32'(start_w[0]), 32'd0);
      check("rst_mid_txdata", 32'(txd_w[0]), 32'd0);
      check("rst_mid_ready", 32'(ready_w[0]), 32'd1);
      check("rst_mid_drop", 32'(drop_w[0]), 32'd0);
      check("rst_mid_drop_hex", 32'(drop_w[1]), 32'd0);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         done_w[0] = (c == 0);
         @(negedge clk);
         if (start_w[0] || mdone_w[0] || !ready_w[0]) bad++;
      end
      tick();
      done_w[0] = 1'b0;
      check("done_ignored_after_rst", 32'(bad), 32'd0);
      run_msg(0, 1'b1, W'($urandom), 3, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
